// File: rtl/serial_shift_register_pkg.sv
// shift_register_pkg: shared defaults and legal limits for serial_shift_register.
package shift_register_pkg;
  localparam int   SHREG_N_DEFAULT       = 10;
  localparam logic SHREG_RST_VAL_DEFAULT = 1'b0;
  localparam int   SHREG_N_MIN           = 1;
endpackage

// File: rtl/serial_shift_register_if.sv
// serial_shift_register_if: serial data bus; par_out exists only with SHREG_PAR_OUT_EN.
interface serial_shift_register_if
  import shift_register_pkg::*;
#(parameter int N = SHREG_N_DEFAULT) ();
  logic         sh_in;
  logic         sh_out;
`ifdef SHREG_PAR_OUT_EN
  logic [N-1:0] par_out;
  modport master (output sh_in, input sh_out, input par_out);
  modport slave (input sh_in, output sh_out, output par_out);
`else
  modport master (output sh_in, input sh_out);
  modport slave (input sh_in, output sh_out);
`endif
endinterface

// File: rtl/serial_shift_register_stage.sv
// shreg_stage: one flip-flop with asynchronous active-low reset to RST_VAL.
module shreg_stage #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= RST_VAL;
    else q <= d;
endmodule

// File: rtl/serial_shift_register.sv
// serial_shift_register: N-cycle serial delay line; define SHREG_PAR_OUT_EN to expose par_out.
module serial_shift_register
  import shift_register_pkg::*;
#(
  parameter int   N       = SHREG_N_DEFAULT,
  parameter logic RST_VAL = SHREG_RST_VAL_DEFAULT
) (
  input logic clk,
  input logic rst,
  serial_shift_register_if.slave bus
);
  if (N < SHREG_N_MIN) begin : g_bad_n
    $fatal(1, "serial_shift_register: N must be >= %0d", SHREG_N_MIN);
  end
  // chain[0] is the serial input; chain[k+1] is the output of stage k
  logic [N:0] chain;
  assign chain[0] = bus.sh_in;
  for (genvar i = 0; i < N; i++) begin : g_stage
    shreg_stage #(.RST_VAL(RST_VAL)) u_stage (
      .clk(clk),
      .rst(rst),
      .d  (chain[i]),
      .q  (chain[i+1])
    );
  end
  assign bus.sh_out = chain[N];
`ifdef SHREG_PAR_OUT_EN
  assign bus.par_out = chain[N:1];
`endif
endmodule

// File: tb/tb_serial_shift_register.sv
// tb_serial_shift_register: randomized and directed checks of serial_shift_register (N=10 and N=1).
module tb_serial_shift_register;
  import shift_register_pkg::*;
  localparam int N = 10;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  always #5 clk = ~clk;
  serial_shift_register_if #(.N(N)) bus();
  serial_shift_register_if #(.N(1)) bus1();
  serial_shift_register #(.N(N), .RST_VAL(1'b0)) dut (.clk(clk), .rst(rst), .bus(bus));
  serial_shift_register #(.N(1), .RST_VAL(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  // reference: a FIFO holding the last N sampled inputs; its head is what sh_out must show
  task automatic model_clear();
    exp_q.delete();
    repeat (N) exp_q.push_back(1'b0);
  endtask

  function automatic logic [N-1:0] model_par();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = exp_q[N-1-k];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) begin
      exp_q.push_back(bus.sh_in);
      void'(exp_q.pop_front());
    end
    #1;
  endtask

  task automatic check_par(input string tag, input logic [N-1:0] want);
`ifdef SHREG_PAR_OUT_EN
    check(tag, bus.par_out, want);
`endif
  endtask

  initial begin
    logic [9:0] w, col;
    bus.sh_in = 1'b1;
    bus1.sh_in = 1'b1;
    model_clear();
    for (int i = 0; i < 10; i++) begin
      step();
      check("rst_sh_out", bus.sh_out, 0);
      check_par("rst_par_out", '0);
    end
    check("rst_sh_out_n1", bus1.sh_out, 0);
    rst = 1'b1;
    bus1.sh_in = 1'b0;
    bus.sh_in = 1'b1;
    step();
    check("pulse_1", bus.sh_out, 0);
    bus.sh_in = 1'b0;
    for (int i = 2; i <= N + 2; i++) begin
      step();
      check($sformatf("pulse_%0d", i), bus.sh_out, (i == N) ? 1 : 0);
    end
    bus.sh_in = 1'b1;
    step();
    check_par("par_walk_0", N'(1));
    bus.sh_in = 1'b0;
    for (int k = 1; k < N; k++) begin
      step();
      check_par($sformatf("par_walk_%0d", k), N'(1) << k);
    end
    for (int it = 0; it < 100; it++) begin
      w = 10'($urandom_range(0, 1023));
      for (int i = 0; i < 10; i++) begin
        bus.sh_in = w[i];
        step();
      end
      col = '0;
      for (int i = 0; i < 10; i++) begin
        col = {bus.sh_out, col[9:1]};
        bus.sh_in = 1'($urandom);
        step();
      end
      check($sformatf("pattern_%0d", it), col, w);
    end
    for (int i = 0; i < 200; i++) begin
      bus.sh_in = 1'($urandom);
      step();
      check("rand_sh_out", bus.sh_out, exp_q[0]);
      check_par("rand_par_out", model_par());
    end
    bus.sh_in = 1'b0;
    repeat (N) step();
    bus.sh_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check_par("mid_pre_par", N'(5'h1F));
    #2 rst = 1'b0;
    model_clear();
    #1;
    check("mid5_sh_out", bus.sh_out, 0);
    check_par("mid5_par", '0);
    step();
    rst = 1'b1;
    for (int i = 0; i < N + 3; i++) step();
    check("mid_pre_sh_out", bus.sh_out, 1);
    #2 rst = 1'b0;
    model_clear();
    #1;
    check("mid_async_sh_out", bus.sh_out, 0);
    check_par("mid_async_par", '0);
    repeat (2) step();
    check("mid_hold_sh_out", bus.sh_out, 0);
    rst = 1'b1;
    for (int i = 1; i <= N; i++) begin
      step();
      check($sformatf("release_%0d", i), bus.sh_out, (i == N) ? 1 : 0);
    end
    for (int i = 0; i < 8; i++) begin
      bus1.sh_in = i[0];
      step();
      check($sformatf("n1_%0d", i), bus1.sh_out, i[0]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
